serial_adder_ctrl: RTL
======================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial addition controller: one shared 1-bit full adder (two Half_Adder instances + OR) is sequenced over WIDTH bits,
//  LSB first, with a registered carry. Trades latency (WIDTH cycles) for area; used where a wide parallel adder is not justified.
//  Single-command interface: Start/Busy/Done. Result {Carry_Out, Sum_Out} equals Data_A_In + Data_B_In as sampled at Start.
// PARAMETERS
//  WIDTH   8   operand/sum width in bits; legal range 1..64
// PORTS
//  Clk        in   1      system clock, all state updates on rising edge
//  Reset      in   1      synchronous, active-high reset
//  Start_In   in   1      request; sampled on rising Clk when Busy_Out=0
//  Data_A_In  in   WIDTH  operand A, captured on accepted Start
//  Data_B_In  in   WIDTH  operand B, captured on accepted Start
//  Busy_Out   out  1      1 while an addition is in progress (state RUN)
//  Done_Out   out  1      1-cycle pulse: result registers just updated
//  Sum_Out    out  WIDTH  result sum, held until next result
//  Carry_Out  out  1      result carry-out of MSB, held with Sum_Out
// BEHAVIOUR
//  Interface: one clock (Clk); reset is synchronous and active-high (Reset).
//  Reset (Reset=1 at a rising edge): state=IDLE, Busy_Out=0, Done_Out=0, Sum_Out=0, Carry_Out=0, bit counter=0, carry reg=0,
//   operand shift regs=0. Reset wins over every other event, including mid-RUN: operation aborted, no Done_Out pulse produced.
//  States: IDLE, RUN, DONE (registered FSM; outputs decoded from registers, no combinational input->output path).
//  IDLE: Start_In=1 -> capture A,B into shift regs, carry reg=0, counter=0, go RUN. Start_In=0 -> stay.
//  RUN (Busy_Out=1): each edge: s = A[0]^B[0]^c; c' = A[0]&B[0] | (A[0]^B[0])&c; s shifted into partial-sum reg at MSB end;
//   A,B shifted right; counter++. On the edge processing bit WIDTH-1: Sum_Out<=final partial sum, Carry_Out<=c', go DONE.
//   Start_In ignored throughout RUN (no queuing, no error flag); Data_A_In/Data_B_In changes have no effect.
//  DONE (Busy_Out=0, Done_Out=1 for exactly this one cycle): Start_In=1 -> accepted as in IDLE, go RUN (back-to-back allowed);
//   else go IDLE. Sum_Out/Carry_Out never change except at the RUN->DONE edge and at reset.
//  Latency: Start accepted at edge E0 -> bits processed on edges E1..E_WIDTH -> Done_Out=1 and result valid in the cycle after
//   E_WIDTH. Throughput: one result per WIDTH+1 cycles when Start held high.
//  Widths: counter is $clog2(WIDTH+1) bits; carry is modulo-free (true WIDTH+1-bit sum). WIDTH=1 -> single RUN cycle.
//  Start_In is level-sampled: held high continuously, a new operation starts every DONE cycle with current operand values.
// TESTING
//  Bench compares {Carry_Out,Sum_Out} === A+B (WIDTH+1 bits) on every Done_Out, counts Passed/Failed/Total, prints summary.
//  1. WIDTH=8, A=8'hFF, B=8'h01, Start 1 cycle -> Busy 8 cycles, Done pulse 1 cycle, Sum_Out=8'h00, Carry_Out=1.
//  2. A=8'h5A, B=8'h25 -> Sum_Out=8'h7F, Carry_Out=0; outputs stay 7F/0 for 20 idle cycles after Done.
//  3. Start A=8'h10,B=8'h20; at RUN cycle 3 pulse Start with A=8'hFF,B=8'hFF -> ignored; result 8'h30/0; only one Done pulse.
//  4. Reset asserted at RUN cycle 4 of A=8'h80,B=8'h80 -> next cycle IDLE, Busy=0, Sum=0, Carry=0, no Done; then 8'h80+8'h80 -> 00/1.
//  5. Start held high, operands 8'h01+8'h01 then 8'hC8+8'h64 -> Done every 9 cycles; results 02/0 then 2C/1.
//  6. 1000 random pairs at WIDTH=8 plus 100 at WIDTH=1 and WIDTH=32 -> Failed_Checks=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full adder (two half adders + OR) stepped LSB-first over WIDTH bits.
// Latency WIDTH+1 cycles from accepted Start to Done; Start is ignored while Busy (no queuing).

module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start_In,
    input  logic [WIDTH-1:0] Data_A_In,
    input  logic [WIDTH-1:0] Data_B_In,
    output logic             Busy_Out,
    output logic             Done_Out,
    output logic [WIDTH-1:0] Sum_Out,
    output logic             Carry_Out
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CW-1:0]    bit_cnt;

    logic             ab_sum;
    logic             ab_carry;
    logic             bit_sum;
    logic             prop_carry;
    logic             carry_next;
    logic [WIDTH-1:0] psum_next;
    logic             accept;

    half_adder u_ha_ab (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .sum   (ab_sum),
        .carry (ab_carry)
    );

    half_adder u_ha_c (
        .a     (ab_sum),
        .b     (carry),
        .sum   (bit_sum),
        .carry (prop_carry)
    );

    assign carry_next = ab_carry | prop_carry;

    // New sum bit enters at the MSB end so after WIDTH steps bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_one_bit
            assign psum_next = bit_sum;
        end else begin : g_multi_bit
            assign psum_next = {bit_sum, psum[WIDTH-1:1]};
        end
    endgenerate

    assign accept   = Start_In && ((state == ST_IDLE) || (state == ST_DONE));
    assign Busy_Out = (state == ST_RUN);
    assign Done_Out = (state == ST_DONE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            psum      <= '0;
            carry     <= 1'b0;
            bit_cnt   <= '0;
            Sum_Out   <= '0;
            Carry_Out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        a_sh    <= Data_A_In;
                        b_sh    <= Data_B_In;
                        psum    <= '0;
                        carry   <= 1'b0;
                        bit_cnt <= '0;
                        state   <= ST_RUN;
                    end else begin
                        state   <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    psum    <= psum_next;
                    carry   <= carry_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        Sum_Out   <= psum_next;
                        Carry_Out <= carry_next;
                        state     <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
